// File: rtl/compute_r_bins_pkg.sv
// Shared widths, latency, saturation limits and FSM encoding for the
// compute_r_bins signed divider.
package compute_r_bins_pkg;

    localparam int DIN0_W  = 33;
    localparam int DIN1_W  = 15;
    localparam int DOUT_W  = 18;
    localparam int LATENCY = 35;
    localparam int CNT_W   = 6;

    localparam logic signed [DOUT_W-1:0] QMAX = 18'sh1FFFF;   //  131071
    localparam logic signed [DOUT_W-1:0] QMIN = 18'sh20000;   // -131072

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

endpackage

// File: rtl/compute_r_bins_sdiv_step.sv
// One restoring division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits.
module compute_r_bins_sdiv_step
    import compute_r_bins_pkg::*;
#(
    parameter int W = DIN1_W
) (
    input  logic [W-1:0] rem_in,
    input  logic         bit_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);

    logic [W:0] shifted;
    logic [W:0] diff;

    // The partial remainder stays below the divisor, so either branch fits W bits.
    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted - {1'b0, divisor};
        q_bit   = (shifted >= {1'b0, divisor});
        rem_out = q_bit ? diff[W-1:0] : shifted[W-1:0];
    end

endmodule

// File: rtl/compute_r_bins_sdiv.sv
// Fixed-latency signed divider: magnitude restoring division MSB first,
// followed by sign correction, saturation and divide-by-zero handling.
module compute_r_bins_sdiv
    import compute_r_bins_pkg::*;
#(
    parameter int din0_WIDTH = DIN0_W,
    parameter int din1_WIDTH = DIN1_W,
    parameter int dout_WIDTH = DOUT_W
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic                         ap_start,
    output logic                         ap_ready,
    output logic                         ap_idle,
    output logic                         ap_done,
    input  logic signed [din0_WIDTH-1:0] din0,
    input  logic signed [din1_WIDTH-1:0] din1,
    output logic signed [dout_WIDTH-1:0] dout,
    output logic signed [din1_WIDTH-1:0] rem,
    output logic                         ovf,
    output logic                         dbz
);

    localparam logic [CNT_W-1:0]      LAST_ITER = CNT_W'(din0_WIDTH - 1);
    localparam logic [din0_WIDTH-1:0] POS_LIM   = din0_WIDTH'(2**(dout_WIDTH-1) - 1);
    localparam logic [din0_WIDTH-1:0] NEG_LIM   = din0_WIDTH'(2**(dout_WIDTH-1));

    state_t state, next_state;

    logic [CNT_W-1:0]      cnt;
    logic [din0_WIDTH-1:0] a_sh;
    logic [din0_WIDTH-1:0] q_sh;
    logic [din1_WIDTH-1:0] b_mag;
    logic [din1_WIDTH-1:0] r_part;
    logic                  s0, s1;

    logic [din0_WIDTH-1:0] a_mag;
    logic [din1_WIDTH-1:0] b_in_mag;
    logic [din1_WIDTH-1:0] r_next;
    logic                  q_bit;

    logic signed [dout_WIDTH-1:0] fix_q, fix_q_c;
    logic signed [din1_WIDTH-1:0] fix_r, fix_r_c;
    logic                         fix_ovf, fix_ovf_c;
    logic                         fix_dbz, fix_dbz_c;
    logic [dout_WIDTH-1:0]        q_trunc;
    logic                         q_neg;

    // Magnitudes are unsigned at full width, so -2^32 maps to 2^32 without wrap.
    assign a_mag    = din0[din0_WIDTH-1] ? -din0 : din0;
    assign b_in_mag = din1[din1_WIDTH-1] ? -din1 : din1;

    assign ap_idle  = (state == S_IDLE);
    assign ap_ready = (state == S_IDLE) && ap_start;

    compute_r_bins_sdiv_step #(
        .W(din1_WIDTH)
    ) u_step (
        .rem_in (r_part),
        .bit_in (a_sh[din0_WIDTH-1]),
        .divisor(b_mag),
        .rem_out(r_next),
        .q_bit  (q_bit)
    );

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (ap_start) next_state = S_CALC;
            S_CALC:  if (cnt == LAST_ITER) next_state = S_FIX;
            S_FIX:   next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        fix_q_c   = '0;
        fix_r_c   = '0;
        fix_ovf_c = 1'b0;
        fix_dbz_c = 1'b0;
        q_neg     = s0 ^ s1;
        q_trunc   = q_sh[dout_WIDTH-1:0];
        if (b_mag == '0) begin
            fix_dbz_c = 1'b1;
            fix_q_c   = s0 ? dout_WIDTH'(QMIN) : dout_WIDTH'(QMAX);
        end else begin
            fix_r_c = s0 ? -r_part : r_part;
            if (!q_neg && (q_sh > POS_LIM)) begin
                fix_q_c   = dout_WIDTH'(QMAX);
                fix_ovf_c = 1'b1;
            end else if (q_neg && (q_sh > NEG_LIM)) begin
                fix_q_c   = dout_WIDTH'(QMIN);
                fix_ovf_c = 1'b1;
            end else begin
                fix_q_c = q_neg ? -q_trunc : q_trunc;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            a_sh    <= '0;
            q_sh    <= '0;
            b_mag   <= '0;
            r_part  <= '0;
            s0      <= 1'b0;
            s1      <= 1'b0;
            fix_q   <= '0;
            fix_r   <= '0;
            fix_ovf <= 1'b0;
            fix_dbz <= 1'b0;
            dout    <= '0;
            rem     <= '0;
            ovf     <= 1'b0;
            dbz     <= 1'b0;
            ap_done <= 1'b0;
        end else begin
            state   <= next_state;
            ap_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        a_sh   <= a_mag;
                        b_mag  <= b_in_mag;
                        s0     <= din0[din0_WIDTH-1];
                        s1     <= din1[din1_WIDTH-1];
                        r_part <= '0;
                        q_sh   <= '0;
                        cnt    <= '0;
                    end
                end
                S_CALC: begin
                    a_sh   <= a_sh << 1;
                    q_sh   <= {q_sh[din0_WIDTH-2:0], q_bit};
                    r_part <= r_next;
                    cnt    <= (cnt == LAST_ITER) ? '0 : cnt + 1'b1;
                end
                S_FIX: begin
                    fix_q   <= fix_q_c;
                    fix_r   <= fix_r_c;
                    fix_ovf <= fix_ovf_c;
                    fix_dbz <= fix_dbz_c;
                end
                S_DONE: begin
                    // Outputs change only together with ap_done and hold until the next one.
                    dout    <= fix_q;
                    rem     <= fix_r;
                    ovf     <= fix_ovf;
                    dbz     <= fix_dbz;
                    ap_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_compute_r_bins_sdiv.sv
// Self-checking bench for compute_r_bins_sdiv: directed and random divisions
// against an integer-arithmetic reference, plus reset-abort and back-to-back timing.
module tb_compute_r_bins_sdiv;

    logic               ap_clk = 1'b0;
    logic               ap_rst;
    logic               ap_start;
    logic               ap_ready;
    logic               ap_idle;
    logic               ap_done;
    logic signed [32:0] din0;
    logic signed [14:0] din1;
    logic signed [17:0] dout;
    logic signed [14:0] rem;
    logic               ovf;
    logic               dbz;

    int total = 0;
    int bad   = 0;

    compute_r_bins_sdiv dut (
        .ap_clk  (ap_clk),
        .ap_rst  (ap_rst),
        .ap_start(ap_start),
        .ap_ready(ap_ready),
        .ap_idle (ap_idle),
        .ap_done (ap_done),
        .din0    (din0),
        .din1    (din1),
        .dout    (dout),
        .rem     (rem),
        .ovf     (ovf),
        .dbz     (dbz)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: truncating integer division, remainder with the dividend's sign.
    task automatic model(input longint a, input longint b, output longint q,
                         output longint r, output longint o, output longint z);
        longint qt;
        o = 0;
        z = 0;
        if (b == 0) begin
            z = 1;
            r = 0;
            q = (a >= 0) ? 131071 : -131072;
        end else begin
            qt = a / b;
            r  = a % b;
            q  = qt;
            if (qt > 131071) begin
                q = 131071;
                o = 1;
            end else if (qt < -131072) begin
                q = -131072;
                o = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Entered #1 after a rising edge with the DUT idle; returns #1 after the
    // edge following ap_done.
    task automatic do_op(input logic signed [32:0] a, input logic signed [14:0] b,
                         input string tag);
        longint q, r, o, z;
        int     lat;
        bit     got;
        din0     = a;
        din1     = b;
        ap_start = 1'b1;
        #1;
        check({tag, ".ready"}, 64'(ap_ready), 64'(1));
        tick();
        ap_start = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 60) begin
            tick();
            lat++;
            if (ap_done) got = 1'b1;
        end
        check({tag, ".latency"}, 64'(lat), 64'(35));
        model(longint'(a), longint'(b), q, r, o, z);
        check({tag, ".dout"}, 64'(dout), q);
        check({tag, ".rem"},  64'(rem),  r);
        check({tag, ".ovf"},  64'(ovf),  o);
        check({tag, ".dbz"},  64'(dbz),  z);
        tick();
        check({tag, ".done_pulse"}, 64'(ap_done), 64'(0));
        check({tag, ".hold"},       64'(dout),    q);
    endtask

    initial begin
        logic signed [32:0] ra;
        logic signed [14:0] rb;
        int                 n, first, second;
        bit                 seen;

        ap_rst   = 1'b1;
        ap_start = 1'b0;
        din0     = '0;
        din1     = '0;
        repeat (3) tick();
        check("rst.idle",  64'(ap_idle),  64'(1));
        check("rst.ready", 64'(ap_ready), 64'(0));
        check("rst.done",  64'(ap_done),  64'(0));
        check("rst.dout",  64'(dout),     64'(0));
        check("rst.rem",   64'(rem),      64'(0));
        check("rst.flags", 64'({ovf, dbz}), 64'(0));
        ap_rst = 1'b0;
        tick();

        do_op(33'sd1000,  15'sd7,  "d1000_7");
        do_op(-33'sd1000, 15'sd7,  "dm1000_7");
        do_op(33'sd1000,  -15'sd7, "d1000_m7");
        do_op(33'sd1048576, 15'sd3, "sat_pos");
        do_op(-33'sd4294967296, -15'sd1, "sat_min_over_m1");
        do_op(33'sd5,  15'sd0, "dbz_pos");
        do_op(-33'sd5, 15'sd0, "dbz_neg");
        do_op(-33'sd393216, 15'sd3, "neg_lim");
        do_op(-33'sd393219, 15'sd3, "neg_sat");
        do_op(33'sd100, -15'sd16384, "div_min");

        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) begin
                ra = 33'($urandom_range(0, 4000000)) - 33'sd2000000;
                rb = 15'($urandom_range(1, 200));
                if ($urandom_range(0, 1) == 1) rb = -rb;
            end else begin
                ra = {1'($urandom_range(0, 1)), 32'($urandom())};
                rb = 15'($urandom());
            end
            do_op(ra, rb, $sformatf("rand%0d", i));
        end

        // Abort mid-division: reset 10 cycles into CALC must suppress ap_done.
        din0     = 33'sd1000;
        din1     = 15'sd7;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        repeat (10) tick();
        ap_rst = 1'b1;
        tick();
        check("abort.idle", 64'(ap_idle), 64'(1));
        check("abort.dout", 64'(dout),    64'(0));
        check("abort.rem",  64'(rem),     64'(0));
        check("abort.flags", 64'({ovf, dbz, ap_done}), 64'(0));
        ap_rst = 1'b0;
        do_op(33'sd1000, 15'sd7, "restart");

        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (ap_done) seen = 1'b1;
        end
        check("abort.no_done", 64'(seen), 64'(0));

        // Start held high: results must come out every 36 cycles.
        din0     = 33'sd1000;
        din1     = 15'sd7;
        ap_start = 1'b1;
        n        = 0;
        first    = -1;
        second   = -1;
        while (second < 0 && n < 150) begin
            tick();
            n++;
            if (ap_done) begin
                if (first < 0) first = n;
                else second = n;
                if (second >= 0) ap_start = 1'b0;
                check("b2b.dout", 64'(dout), 64'(142));
                check("b2b.rem",  64'(rem),  64'(6));
            end
        end
        ap_start = 1'b0;
        check("b2b.first",   64'(first),          64'(36));
        check("b2b.spacing", 64'(second - first), 64'(36));
        tick();
        tick();
        check("b2b.idle", 64'(ap_idle), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/compute_r_bins_sdiv.md
COMPUTE_R_BINS_SDIV -- requirements
Module: compute_r_bins_sdiv

Interface
REQ-001 Parameter: din0_WIDTH, 33, signed dividend width.
REQ-002 Parameter: din1_WIDTH, 15, signed divisor width.
REQ-003 Parameter: dout_WIDTH, 18, signed quotient width.
REQ-004 Ports:
- ap_clk  in  1  sole clock; all state on rising edge.
- ap_rst  in  1  reset; asynchronous, active-high.
- ap_start  in  1  request; operands sampled when accepted.
- ap_ready  out  1  one-cycle pulse on the acceptance cycle.
- ap_idle  out  1  high while in IDLE.
- ap_done  out  1  one-cycle pulse; results valid from this cycle.
- din0  in  din0_WIDTH  signed dividend.
- din1  in  din1_WIDTH  signed divisor.
- dout  out  dout_WIDTH  signed quotient.
- rem  out  din1_WIDTH  signed remainder.
- ovf  out  1  quotient saturated.
- dbz  out  1  divisor was zero.

Function
REQ-005 The block SHALL be the inverse of the 18x15 signed multiplier: dout = trunc(din0/din1) toward zero; rem = din0 - dout*din1, with the sign of din0 (or zero).
REQ-006 FSM states and transitions:
- IDLE -> CALC when ap_start=1 (acceptance cycle).
- CALC -> FIX after exactly din0_WIDTH iterations.
- FIX -> DONE.
- DONE -> IDLE unconditionally.
REQ-007 On acceptance, the block SHALL:
- latch operand magnitudes as unsigned din0_WIDTH / din1_WIDTH values;
- latch both sign bits;
- assert ap_ready for that cycle only.
REQ-008 CALC SHALL perform one restoring shift-subtract step per cycle, MSB first, for 33 cycles; an iteration counter runs 0..32.
REQ-009 FIX SHALL apply sign correction, saturation and flag evaluation.
REQ-010 ap_done SHALL assert exactly 35 cycles after the acceptance edge. Latency is fixed, including divide-by-zero.
REQ-011 ap_start outside IDLE SHALL be ignored; no queuing.
REQ-012 dout, rem, ovf and dbz SHALL hold their values from ap_done until the next ap_done.
REQ-013 Overflow:
- a true quotient above 131071 SHALL give dout=131071, ovf=1;
- a true quotient below -131072 SHALL give dout=-131072, ovf=1;
- rem SHALL still be the true remainder.
REQ-014 Divide-by-zero (din1=0) SHALL give:
- dbz=1, ovf=0, rem=0;
- dout=131071 if din0>=0, otherwise -131072.
REQ-015 Internal magnitude arithmetic SHALL use din0_WIDTH bits, so |-2^32| = 2^32 is represented without wrap.
REQ-016 Remainder magnitude is always < |din1|, so it fits din1_WIDTH signed; no truncation error is permitted.

Reset
REQ-017 While ap_rst=1, the block SHALL force:
- state=IDLE, counter=0;
- ap_idle=1, ap_ready=0, ap_done=0;
- dout=0, rem=0, ovf=0, dbz=0.
REQ-018 Reset mid-operation SHALL abort the division without producing ap_done.
REQ-019 A start on the first cycle after reset release SHALL be accepted normally.

Structure
REQ-020 Package compute_r_bins_pkg SHALL hold:
- the width constants (33/15/18);
- LATENCY=35;
- the QMAX/QMIN saturation constants;
- the FSM state enum.
REQ-021 One sub-module, compute_r_bins_sdiv_step, SHALL implement the single combinational restoring iteration (partial remainder, next dividend bit -> next remainder, quotient bit); the top module holds the FSM and registers.

Verification
REQ-022 din0=1000, din1=7 -> dout=142, rem=6, ovf=0, dbz=0; ap_done exactly 35 cycles after acceptance.
REQ-023 din0=-1000, din1=7 -> dout=-142, rem=-6; and din0=1000, din1=-7 -> dout=-142, rem=6.
REQ-024 Saturation cases:
- din0=1048576, din1=3 -> dout=131071, rem=1, ovf=1;
- din0=-2^32, din1=-1 -> dout=131071, rem=0, ovf=1.
REQ-025 Divide-by-zero: din0=5, din1=0 -> dout=131071, dbz=1; din0=-5, din1=0 -> dout=-131072, dbz=1; both with latency 35.
REQ-026 Reset and overlap:
- ap_rst pulsed 10 cycles into CALC -> no ap_done; all outputs 0.
- A restart with 1000/7 after the abort -> 142/6 at latency 35.
- ap_start held high throughout -> back-to-back results spaced exactly 36 cycles apart.
